// File: rtl/sc_lanedriver_if.sv
// Handshake/bus bundle between the lane driver and its host: game controls in,
// lane register commands and pattern data out.
interface sc_lanedriver_if #(
    parameter int unsigned LANE_DATAWIDTH = 12
);
    logic                      SC_LANEDRIVER_start_InLow;
    logic                      SC_LANEDRIVER_pause_InHigh;
    logic [1:0]                SC_LANEDRIVER_level_InBUS;
    logic                      SC_LANEDRIVER_clear_OutLow;
    logic                      SC_LANEDRIVER_load_OutLow;
    logic [1:0]                SC_LANEDRIVER_shiftselection_Out;
    logic [LANE_DATAWIDTH-1:0] SC_LANEDRIVER_data_OutBUS;
    logic [3:0]                SC_LANEDRIVER_random_OutBUS;
    logic [7:0]                SC_LANEDRIVER_shiftcount_OutBUS;

    modport master (
        output SC_LANEDRIVER_start_InLow,
        output SC_LANEDRIVER_pause_InHigh,
        output SC_LANEDRIVER_level_InBUS,
        input  SC_LANEDRIVER_clear_OutLow,
        input  SC_LANEDRIVER_load_OutLow,
        input  SC_LANEDRIVER_shiftselection_Out,
        input  SC_LANEDRIVER_data_OutBUS,
        input  SC_LANEDRIVER_random_OutBUS,
        input  SC_LANEDRIVER_shiftcount_OutBUS
    );

    modport slave (
        input  SC_LANEDRIVER_start_InLow,
        input  SC_LANEDRIVER_pause_InHigh,
        input  SC_LANEDRIVER_level_InBUS,
        output SC_LANEDRIVER_clear_OutLow,
        output SC_LANEDRIVER_load_OutLow,
        output SC_LANEDRIVER_shiftselection_Out,
        output SC_LANEDRIVER_data_OutBUS,
        output SC_LANEDRIVER_random_OutBUS,
        output SC_LANEDRIVER_shiftcount_OutBUS
    );
endinterface

// File: rtl/sc_lanedriver.sv
// Lane driver: sequences clear/load of the lane register on start, then issues
// shift pulses at a level-dependent rate with an LFSR refill nibble.
module sc_lanedriver #(
    parameter int unsigned               TICK_BASE      = 12500000,
    parameter int unsigned               LANE_DATAWIDTH = 12,
    parameter logic [LANE_DATAWIDTH-1:0] INIT_PATTERN   = 12'b000011110000,
    parameter logic [7:0]                LFSR_SEED      = 8'hA5
) (
    input  logic               SC_LANEDRIVER_CLOCK_50,
    input  logic               SC_LANEDRIVER_RESET_InHigh,
    sc_lanedriver_if.slave     bus_io
);
    typedef enum logic [2:0] {StIdle, StClear, StLoad, StRun, StPause} state_e;

    state_e      state_q, state_d;
    logic [31:0] tick_q, tick_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic [31:0] period, term;
    logic        clear_n, load_n;
    logic [1:0]  shift_sel;

    // Periods of 0 or 1 collapse to a terminal count of 0: pulse every RUN cycle.
    always_comb begin
        period = 32'(TICK_BASE) >> bus_io.SC_LANEDRIVER_level_InBUS;
        term   = (period <= 32'd1) ? 32'd0 : period - 32'd1;
    end

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        cnt_d     = cnt_q;
        clear_n   = 1'b1;
        load_n    = 1'b1;
        shift_sel = 2'b11;
        lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        unique case (state_q)
            StIdle: begin
                if (!bus_io.SC_LANEDRIVER_start_InLow) state_d = StClear;
            end
            StClear: begin
                clear_n = 1'b0;
                state_d = StLoad;
            end
            StLoad: begin
                load_n  = 1'b0;
                tick_d  = '0;
                cnt_d   = '0;
                state_d = StRun;
            end
            StRun: begin
                // Pause beats a due pulse; the counter is simply held.
                if (bus_io.SC_LANEDRIVER_pause_InHigh) begin
                    state_d = StPause;
                end else if (tick_q >= term) begin
                    shift_sel = 2'b10;
                    tick_d    = '0;
                    cnt_d     = cnt_q + 8'd1;
                end else begin
                    tick_d = tick_q + 32'd1;
                end
            end
            StPause: begin
                if (!bus_io.SC_LANEDRIVER_pause_InHigh) state_d = StRun;
            end
            default: state_d = StIdle;
        endcase
        // Reset is synchronous, so mask the command outputs while it is held.
        if (SC_LANEDRIVER_RESET_InHigh) begin
            clear_n   = 1'b1;
            load_n    = 1'b1;
            shift_sel = 2'b11;
        end
    end

    always_ff @(posedge SC_LANEDRIVER_CLOCK_50) begin
        if (SC_LANEDRIVER_RESET_InHigh) begin
            state_q <= StIdle;
            tick_q  <= '0;
            cnt_q   <= '0;
            lfsr_q  <= LFSR_SEED;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
        end
    end

    assign bus_io.SC_LANEDRIVER_clear_OutLow       = clear_n;
    assign bus_io.SC_LANEDRIVER_load_OutLow        = load_n;
    assign bus_io.SC_LANEDRIVER_shiftselection_Out = shift_sel;
    assign bus_io.SC_LANEDRIVER_data_OutBUS        = INIT_PATTERN;
    assign bus_io.SC_LANEDRIVER_random_OutBUS      = lfsr_q[3:0];
    assign bus_io.SC_LANEDRIVER_shiftcount_OutBUS  = cnt_q;
endmodule

// File: tb/tb_sc_lanedriver.sv
// Directed bench for sc_lanedriver with TICK_BASE=8: start sequence, pulse
// timing per level, pause priority, level switch, LFSR sequence, reset priority.
module tb_sc_lanedriver;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    sc_lanedriver_if #(.LANE_DATAWIDTH(12)) bus ();

    sc_lanedriver #(
        .TICK_BASE     (8),
        .LANE_DATAWIDTH(12)
    ) u_dut (
        .SC_LANEDRIVER_CLOCK_50    (clk),
        .SC_LANEDRIVER_RESET_InHigh(rst),
        .bus_io                    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [1:0] shsel;
    logic [7:0] scnt;
    logic       clr_n;
    logic       ld_n;
    logic [3:0] rnd;
    assign shsel = bus.SC_LANEDRIVER_shiftselection_Out;
    assign scnt  = bus.SC_LANEDRIVER_shiftcount_OutBUS;
    assign clr_n = bus.SC_LANEDRIVER_clear_OutLow;
    assign ld_n  = bus.SC_LANEDRIVER_load_OutLow;
    assign rnd   = bus.SC_LANEDRIVER_random_OutBUS;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] lfsr_m;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        bus.SC_LANEDRIVER_start_InLow  = 1'b1;
        bus.SC_LANEDRIVER_pause_InHigh = 1'b0;
        bus.SC_LANEDRIVER_level_InBUS  = 2'd0;
        step();
        step();
        check_eq("rst_clear", 32'(clr_n), 32'd1);
        check_eq("rst_load", 32'(ld_n), 32'd1);
        check_eq("rst_shsel", 32'(shsel), 32'h3);
        check_eq("rst_scnt", 32'(scnt), 32'd0);
        check_eq("rst_rand", 32'(rnd), 32'h5);
        check_eq("data", 32'(bus.SC_LANEDRIVER_data_OutBUS), 32'h0F0);

        // LFSR: x^8+x^6+x^5+x^4+1 model, full 255-step period while idle
        rst = 1'b0;
        lfsr_m = 8'hA5;
        step();
        lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
        check_eq("lfsr_first", 32'(rnd), 32'hA);
        for (int i = 1; i < 255; i++) begin
            step();
            lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
            check_eq("lfsr_seq", 32'(rnd), 32'(lfsr_m[3:0]));
        end
        check_eq("lfsr_period", 32'(rnd), 32'h5);
        check_eq("idle_shsel", 32'(shsel), 32'h3);

        // Start sequence
        bus.SC_LANEDRIVER_start_InLow = 1'b0;
        #1;
        check_eq("idle_clear", 32'(clr_n), 32'd1);
        step();
        bus.SC_LANEDRIVER_start_InLow = 1'b1;
        check_eq("clr_clear", 32'(clr_n), 32'd0);
        check_eq("clr_load", 32'(ld_n), 32'd1);
        step();
        check_eq("ld_clear", 32'(clr_n), 32'd1);
        check_eq("ld_load", 32'(ld_n), 32'd0);
        check_eq("ld_data", 32'(bus.SC_LANEDRIVER_data_OutBUS), 32'h0F0);
        step();

        // Level 0: pulse every 8th RUN cycle
        for (int k = 1; k <= 32; k++) begin
            check_eq("lvl0_shsel", 32'(shsel), (k % 8 == 0) ? 32'h2 : 32'h3);
            check_eq("run_clear", 32'(clr_n & ld_n), 32'd1);
            step();
        end
        check_eq("lvl0_scnt", 32'(scnt), 32'd4);

        bus.SC_LANEDRIVER_level_InBUS = 2'd2;
        #1;
        for (int k = 1; k <= 6; k++) begin
            check_eq("lvl2_shsel", 32'(shsel), (k % 2 == 0) ? 32'h2 : 32'h3);
            step();
        end
        check_eq("lvl2_scnt", 32'(scnt), 32'd7);

        // Pause on the cycle the pulse is due
        bus.SC_LANEDRIVER_level_InBUS = 2'd0;
        #1;
        for (int k = 1; k <= 7; k++) begin
            check_eq("pre_pause", 32'(shsel), 32'h3);
            step();
        end
        bus.SC_LANEDRIVER_pause_InHigh = 1'b1;
        #1;
        check_eq("pause_wins", 32'(shsel), 32'h3);
        step();
        check_eq("pause_hold", 32'(shsel), 32'h3);
        check_eq("pause_scnt", 32'(scnt), 32'd7);
        step();
        check_eq("pause_hold2", 32'(shsel), 32'h3);
        bus.SC_LANEDRIVER_pause_InHigh = 1'b0;
        #1;
        check_eq("pause_rel", 32'(shsel), 32'h3);
        step();
        check_eq("resume_pulse", 32'(shsel), 32'h2);
        step();
        check_eq("resume_after", 32'(shsel), 32'h3);
        check_eq("resume_scnt", 32'(scnt), 32'd8);

        // Count 5 at level 0, switch to level 1
        for (int k = 0; k < 5; k++) begin
            check_eq("cnt_up", 32'(shsel), 32'h3);
            step();
        end
        bus.SC_LANEDRIVER_level_InBUS = 2'd1;
        #1;
        check_eq("lvl_switch", 32'(shsel), 32'h2);
        step();
        check_eq("lvl1_zero", 32'(shsel), 32'h3);
        check_eq("lvl1_scnt", 32'(scnt), 32'd9);
        step();
        step();
        check_eq("lvl1_c2", 32'(shsel), 32'h3);
        step();
        check_eq("lvl1_pulse", 32'(shsel), 32'h2);

        // Restart at level 3 (period 1), then reset mid-RUN
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.SC_LANEDRIVER_level_InBUS = 2'd3;
        bus.SC_LANEDRIVER_start_InLow = 1'b0;
        step();
        bus.SC_LANEDRIVER_start_InLow = 1'b1;
        check_eq("re_clear", 32'(clr_n), 32'd0);
        step();
        check_eq("re_load", 32'(ld_n), 32'd0);
        step();
        for (int k = 1; k <= 3; k++) begin
            check_eq("lvl3_shsel", 32'(shsel), 32'h2);
            step();
        end
        check_eq("lvl3_scnt", 32'(scnt), 32'd3);
        rst = 1'b1;
        #1;
        check_eq("mrst_shsel", 32'(shsel), 32'h3);
        check_eq("mrst_cl", 32'(clr_n & ld_n), 32'd1);
        step();
        check_eq("mrst_scnt", 32'(scnt), 32'd0);
        check_eq("mrst_shsel2", 32'(shsel), 32'h3);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check_eq("post_idle", 32'(shsel), 32'h3);
            check_eq("post_clear", 32'(clr_n), 32'd1);
        end
        check_eq("post_scnt", 32'(scnt), 32'd0);
        bus.SC_LANEDRIVER_start_InLow = 1'b0;
        step();
        bus.SC_LANEDRIVER_start_InLow = 1'b1;
        check_eq("post_start", 32'(clr_n), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/sc_lanedriver.md
SC_LANEDRIVER -- requirements
Module: sc_lanedriver

Interface
REQ-001 Parameter TICK_BASE, default 12500000: shift period in clock cycles at level 0; period = TICK_BASE >> level.
REQ-002 Parameter LANE_DATAWIDTH, default 12: width of the lane pattern bus.
REQ-003 Parameter INIT_PATTERN, default 12'b000011110000: pattern loaded into the lane register at game start.
REQ-004 Parameter LFSR_SEED, default 8'hA5, nonzero: LFSR reset value.
REQ-005 SC_LANEDRIVER_CLOCK_50  in  1  the block's single clock, rising edge active.
REQ-006 SC_LANEDRIVER_RESET_InHigh  in  1  reset, synchronous and active-high.
REQ-007 SC_LANEDRIVER_start_InLow  in  1  start request, active low, sampled each clock.
REQ-008 SC_LANEDRIVER_pause_InHigh  in  1  pause request, level-sensitive.
REQ-009 SC_LANEDRIVER_level_InBUS  in  2  speed level, 0 slowest to 3 fastest.
REQ-010 SC_LANEDRIVER_clear_OutLow  out  1  lane register clear command, active low.
REQ-011 SC_LANEDRIVER_load_OutLow  out  1  lane register load command, active low.
REQ-012 SC_LANEDRIVER_shiftselection_Out  out  2  2'b10 = shift this cycle; 2'b11 = hold.
REQ-013 SC_LANEDRIVER_data_OutBUS  out  LANE_DATAWIDTH  load pattern, constantly INIT_PATTERN.
REQ-014 SC_LANEDRIVER_random_OutBUS  out  4  refill nibble = LFSR[3:0].
REQ-015 SC_LANEDRIVER_shiftcount_OutBUS  out  8  number of shifts issued since the last start, wraps 255->0.

Function
REQ-016 The FSM SHALL have the states IDLE, CLEAR, LOAD, RUN, and PAUSE.
REQ-017 IDLE SHALL go to CLEAR when start_InLow=0; otherwise it SHALL stay in IDLE.
REQ-018 CLEAR SHALL drive clear_OutLow=0 for exactly one cycle, then go to LOAD.
REQ-019 LOAD SHALL drive load_OutLow=0 for exactly one cycle, clear shiftcount and the tick counter, then go to RUN.
REQ-020 In RUN, pause_InHigh=1 SHALL go to PAUSE; start_InLow=0 SHALL be ignored.
REQ-021 PAUSE SHALL return to RUN when pause_InHigh=0.
REQ-022 PAUSE SHALL hold the tick counter and shiftcount, and SHALL output shiftselection=2'b11.
REQ-023 Outside CLEAR and LOAD, clear_OutLow and load_OutLow SHALL be 1; the two SHALL never be low together.
REQ-024 Tick counter in RUN SHALL increment each cycle; at count >= (TICK_BASE>>level)-1: shiftselection=2'b10 for that cycle, counter->0, shiftcount+1.
REQ-025 First shift pulse after entering RUN SHALL occur on the (TICK_BASE>>level)-th RUN cycle.
REQ-026 Level change mid-count SHALL apply immediately; if count already >= new period-1 then pulse on the next RUN cycle.
REQ-027 Level 3 with TICK_BASE>>3 <= 1 SHALL pulse every RUN cycle.
REQ-028 Shift pulse is at most one cycle wide; never asserted outside RUN.
REQ-029 pause_InHigh=1 on the same cycle a pulse is due: pause SHALL win, no pulse, counter held.
REQ-030 The LFSR SHALL be 8-bit Fibonacci, shift-left, new LSB = b7^b5^b4^b3, advancing every non-reset cycle in all states.
REQ-031 random_OutBUS SHALL be valid in the same cycle as the shift pulse.
REQ-032 The LFSR SHALL never reach 0 from a nonzero seed.

Reset
REQ-033 On a clock edge with RESET_InHigh=1: state=IDLE, tick counter=0, shiftcount=0, LFSR=LFSR_SEED.
REQ-034 During reset, outputs SHALL be: clear_OutLow=1, load_OutLow=1, shiftselection=2'b11.
REQ-035 Reset SHALL have priority over all other inputs, including mid-RUN and mid-PAUSE, and SHALL take effect on the same edge.

Verification (TICK_BASE=8)
REQ-036 Start sequence: reset, then start_InLow=0 for 1 cycle -> clear low one cycle, load low the next, then RUN; data_OutBUS=12'h0F0 throughout.
REQ-037 Level 0 in RUN for 32 cycles -> pulses on RUN cycles 8/16/24/32, shiftcount=4; level 2 -> pulse every 2nd cycle.
REQ-038 LFSR: one cycle after reset -> LFSR=8'h4A, random=4'hA; 255-cycle period with no zero state.
REQ-039 pause_InHigh=1 on the cycle a pulse is due -> no pulse; release -> pulse on the first RUN cycle, shiftcount +1 only.
REQ-040 Count=5 at level 0, switch to level 1 (period 4) -> pulse next cycle, counter->0.
REQ-041 Reset asserted mid-RUN with shiftcount=3 -> next edge IDLE, shiftcount=0, no pulse, start required to resume.
